decode_stage: RTL
=================

Name: decode_stage

Overview:
RV32I instruction-decode pipeline stage sitting directly upstream of the register file. It accepts fetched instructions over a valid/ready handshake and drives the regfile read addresses. It combines the async read data with a writeback bypass, decodes control and immediates, and registers everything into an ID/EX output register. It detects load-use hazards, inserts bubbles, honours pipeline flush, and counts inserted bubbles.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width (32 architectural registers)
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
if_valid  in  1  fetch presents an instruction
if_ready  out  1  stage accepts the instruction this cycle
if_instr  in  32  instruction word
if_pc  in  XLEN  instruction address
rf_addr_a  out  REG_AW  regfile read address A (rs1)
rf_addr_b  out  REG_AW  regfile read address B (rs2)
rf_a  in  XLEN  regfile async read data A
rf_b  in  XLEN  regfile async read data B
wb_we  in  1  writeback write enable, same cycle as the regfile write
wb_rd  in  REG_AW  writeback destination
wb_data  in  XLEN  writeback data
flush  in  1  squash the stage (branch mispredict or redirect)
ex_valid  out  1  output register holds an instruction
ex_ready  in  1  EX consumes the output this cycle
ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN  registered operands
ex_rd  out  REG_AW  destination (0 if no writeback)
ex_alu_op  out  4  alu_op_e
ex_reg_we, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_illegal  out  1  control flags
bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Single clock domain. clk and rst are the only timing inputs. Reset is synchronous, active-high. Decisions taken at posedge clk.
- Reset: ex_valid=0, all ex_* payload=0, bubble_cnt=0.
- rf_addr_a/rf_addr_b = if_instr[19:15]/[24:20]. These are combinational and driven regardless of if_valid.
- Operand select, per source:
  - rs==0 gives 0.
  - Else, wb_we && wb_rd==rs gives wb_data (bypass, because the regfile write lands at the same edge).
  - Else rf_a/rf_b.
- rs1 is used by all formats except LUI, AUIPC and JAL. rs2 is used only by OP, STORE and BRANCH.
- hazard = ex_valid && ex_mem_rd && ex_rd!=0 && (ex_rd==rs1 used || ex_rd==rs2 used).
- adv = !ex_valid || ex_ready.
- if_ready = adv && !hazard && !flush.
- Update rules at each posedge, in priority order:
  1. rst: reset values.
  2. flush: ex_valid<=0. The incoming instruction is dropped (if_ready was 0).
  3. adv && hazard: ex_valid<=0 (bubble). bubble_cnt increments, saturating at all-ones. Payload is don't-care.
  4. adv && if_valid: load the decoded instruction, ex_valid<=1.
  5. adv && !if_valid: ex_valid<=0.
  6. Otherwise hold all ex_* outputs stable.
- Latency: 1 cycle from accepted instruction to ex_valid.
- Throughput: 1 per cycle absent hazards. A load-use pair costs exactly 1 bubble.
- Decode supports LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - Any other opcode, or a reserved funct3/funct7 combination, sets ex_illegal=1 with reg_we, mem_rd and mem_wr forced to 0.
  - The illegal instruction still flows (ex_valid=1).
- Immediates are sign-extended to XLEN: I, S, B (bit0=0), U ({imm[31:12],12'b0}) and J (bit0=0).
- ex_rd is forced to 0 when the instruction does not write a register (STORE, BRANCH, illegal).
- ex_reg_we=1 iff ex_rd!=0.
- flush and hazard in the same cycle: flush wins and no bubble is counted.
- rst asserted mid-stall: reset wins and the stall state is lost.

Decomposition:
- riscv_pkg holds XLEN, opcode localparams (OPC_LUI..OPC_OP), alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB), imm_type_e (I, S, B, U, J, NONE), and a packed id_ex_t struct for the output register.
- Sub-module imm_gen is purely combinational: instruction plus imm_type_e gives the XLEN immediate.
- The stage itself holds the decoder, the hazard logic, the register and the counter.

Test Plan:
- Reset, then if_instr=0x00500093 (addi x1,x0,5) with ex_ready=1: next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_alu_op=ADD, ex_reg_we=1, ex_rs1_val=0.
- 0x0000A103 (lw x2,0(x1)) followed by 0x001101B3 (add x3,x2,x1): if_ready=0 for one cycle, one bubble (ex_valid=0), bubble_cnt=1, then the add issues.
- wb_we=1, wb_rd=1, wb_data=0xDEADBEEF, rf_a=0, instruction add x3,x1,x0: ex_rs1_val=0xDEADBEEF. Repeat with wb_rd=0: ex_rs1_val=0.
- 0xFE000EE3 (beq x0,x0,-4): ex_imm=0xFFFFFFFC, ex_branch=1, ex_rd=0. 0xFFF00093: ex_imm=0xFFFFFFFF.
- ex_ready=0 for 3 cycles with a valid output: all ex_* are stable and if_ready=0. Then flush=1: next cycle ex_valid=0.
- if_instr=0xFFFFFFFF: ex_illegal=1, ex_reg_we=0, ex_mem_rd=0, ex_mem_wr=0. Force 2^16+3 hazards: bubble_cnt=0xFFFF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I types for the decode stage: opcodes, ALU ops, immediate
// formats and the packed ID/EX register layout.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    alu_op_e           alu_op;
    logic              reg_we;
    logic              mem_rd;
    logic              mem_wr;
    logic              branch;
    logic              jump;
    logic              illegal;
  } id_ex_t;

  // alt selects SUB/SRA; callers only set it where funct7[5] is meaningful.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; every format is sign-extended
// from instr[31], and NONE yields zero.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    // NOTE: every path assigns imm (default first), so no latch is inferred.
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: regfile addressing with writeback bypass, control and
// immediate decode, load-use bubble insertion, flush, and the ID/EX register.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic [REG_AW-1:0] rf_addr_a,
  output logic [REG_AW-1:0] rf_addr_b,
  input  logic [XLEN-1:0]   rf_a,
  input  logic [XLEN-1:0]   rf_b,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_alu_op,
  output logic              ex_reg_we,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [REG_AW-1:0] rs1, rs2;

  assign opcode    = if_instr[6:0];
  assign f3        = if_instr[14:12];
  assign f7        = if_instr[31:25];
  assign rs1       = if_instr[19:15];
  assign rs2       = if_instr[24:20];
  assign rf_addr_a = rs1;
  assign rf_addr_b = rs2;

  // The regfile write lands at the same edge that captures ID/EX, so a
  // matching writeback must be forwarded here.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rf,
    input logic              we,
    input logic [REG_AW-1:0] wrd,
    input logic [XLEN-1:0]   wdata
  );
    if (rs == '0)              return '0;
    else if (we && wrd == rs) return wdata;
    else                      return rf;
  endfunction

  imm_type_e imm_type;
  alu_op_e   alu_op;
  logic      writes_rd, mem_rd, mem_wr, branch, jump, illegal;
  logic      rs1_used, rs2_used;
  logic [XLEN-1:0] imm;

  always_comb begin
    imm_type  = IMM_NONE;
    alu_op    = ALU_ADD;
    writes_rd = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    case (opcode)
      OPC_LUI:   begin imm_type = IMM_U; alu_op = ALU_PASSB; writes_rd = 1'b1; rs1_used = 1'b0; end
      OPC_AUIPC: begin imm_type = IMM_U; writes_rd = 1'b1; rs1_used = 1'b0; end
      OPC_JAL:   begin imm_type = IMM_J; writes_rd = 1'b1; jump = 1'b1; rs1_used = 1'b0; end
      OPC_JALR: begin
        imm_type = IMM_I; writes_rd = 1'b1; jump = 1'b1;
        illegal  = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        imm_type = IMM_B; alu_op = ALU_SUB; branch = 1'b1; rs2_used = 1'b1;
        illegal  = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        imm_type = IMM_I; writes_rd = 1'b1; mem_rd = 1'b1;
        illegal  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        imm_type = IMM_S; mem_wr = 1'b1; rs2_used = 1'b1;
        illegal  = (f3 > 3'b010);
      end
      OPC_OP_IMM: begin
        imm_type  = IMM_I; writes_rd = 1'b1;
        alu_op    = alu_decode(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)      illegal = (f7 != 7'b0000000);
        else if (f3 == 3'b101) illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OPC_OP: begin
        writes_rd = 1'b1; rs2_used = 1'b1;
        alu_op    = alu_decode(f3, f7[5]);
        illegal   = !((f7 == 7'b0000000) ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      writes_rd = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
    end
  end

  imm_gen u_imm_gen (
    .instr    (if_instr[31:7]),
    .imm_type (imm_type),
    .imm      (imm)
  );

  id_ex_t d, q;

  always_comb begin
    d         = '0;
    d.pc      = if_pc;
    d.rs1_val = sel_operand(rs1, rf_a, wb_we, wb_rd, wb_data);
    d.rs2_val = sel_operand(rs2, rf_b, wb_we, wb_rd, wb_data);
    d.imm     = imm;
    d.rd      = writes_rd ? if_instr[11:7] : '0;
    d.alu_op  = alu_op;
    d.reg_we  = (d.rd != '0);
    d.mem_rd  = mem_rd;
    d.mem_wr  = mem_wr;
    d.branch  = branch;
    d.jump    = jump;
    d.illegal = illegal;
  end

  logic hazard, adv;

  assign hazard   = ex_valid && q.mem_rd && (q.rd != '0) &&
                    ((rs1_used && q.rd == rs1) || (rs2_used && q.rd == rs2));
  assign adv      = !ex_valid || ex_ready;
  assign if_ready = adv && !hazard && !flush;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      q          <= '0;
      ex_valid   <= 1'b0;
      bubble_cnt <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (adv) begin
      if (hazard) begin
        ex_valid <= 1'b0;
        if (bubble_cnt != {CNT_W{1'b1}}) bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else if (if_valid) begin
        q        <= d;
        ex_valid <= 1'b1;
      end else begin
        ex_valid <= 1'b0;
      end
    end
  end

  assign ex_pc      = q.pc;
  assign ex_rs1_val = q.rs1_val;
  assign ex_rs2_val = q.rs2_val;
  assign ex_imm     = q.imm;
  assign ex_rd      = q.rd;
  assign ex_alu_op  = q.alu_op;
  assign ex_reg_we  = q.reg_we;
  assign ex_mem_rd  = q.mem_rd;
  assign ex_mem_wr  = q.mem_wr;
  assign ex_branch  = q.branch;
  assign ex_jump    = q.jump;
  assign ex_illegal = q.illegal;

endmodule
